// File: rtl/mips_ctrl_pkg.sv
// Shared encodings and the decoded control bundle for the MIPS control pipeline.
// Used by ctrl_decode and ctrl_pipe; forwarding is enabled with CTRL_PIPE_FWD_EN.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    typedef enum logic [1:0] {
        PC_PLUS4  = 2'b00,
        PC_BRANCH = 2'b01,
        PC_JUMP   = 2'b10
    } pc_src_e;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,
        ALU_FUNCT = 2'b10,
        ALU_LUI   = 2'b11
    } alu_op_e;

    typedef enum logic [1:0] {
        FWD_REG   = 2'b00,
        FWD_MEMWB = 2'b01,
        FWD_EXMEM = 2'b10
    } fwd_e;

    typedef enum logic [1:0] {
        DST_NONE = 2'b00,
        DST_RT   = 2'b01,
        DST_RD   = 2'b10,
        DST_LINK = 2'b11
    } dst_sel_e;

    typedef struct packed {
        logic     reg_write;
        logic     mem_to_reg;
        logic     mem_read;
        logic     mem_write;
        logic     alu_src_b;
        logic     imm_command;
        alu_op_e  alu_op;
        logic     link;
        dst_sel_e dst_sel;
        logic     uses_rs;
        logic     uses_rt;
        logic     is_branch;
        logic     is_bne;
        logic     is_jump;
    } ctrl_bundle_t;

    function automatic ctrl_bundle_t bubble_bundle();
        ctrl_bundle_t b;
        b.reg_write   = 1'b0;
        b.mem_to_reg  = 1'b0;
        b.mem_read    = 1'b0;
        b.mem_write   = 1'b0;
        b.alu_src_b   = 1'b0;
        b.imm_command = 1'b0;
        b.alu_op      = ALU_ADD;
        b.link        = 1'b0;
        b.dst_sel     = DST_NONE;
        b.uses_rs     = 1'b0;
        b.uses_rt     = 1'b0;
        b.is_branch   = 1'b0;
        b.is_bne      = 1'b0;
        b.is_jump     = 1'b0;
        return b;
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Purely combinational opcode-to-control-bundle decoder for the ID stage.
// Unknown opcodes and invalid slots decode to an all-zero bubble.
module ctrl_decode
    import mips_ctrl_pkg::*;
(
    input  logic         valid,
    input  logic [5:0]   opcode,
    output ctrl_bundle_t bundle
);

    always_comb begin
        bundle = bubble_bundle();
        if (valid) begin
            case (opcode)
                OP_LW: begin
                    bundle.reg_write  = 1'b1;
                    bundle.mem_to_reg = 1'b1;
                    bundle.mem_read   = 1'b1;
                    bundle.alu_src_b  = 1'b1;
                    bundle.dst_sel    = DST_RT;
                    bundle.uses_rs    = 1'b1;
                end
                OP_SW: begin
                    bundle.mem_write = 1'b1;
                    bundle.alu_src_b = 1'b1;
                    bundle.uses_rs   = 1'b1;
                    bundle.uses_rt   = 1'b1;
                end
                OP_BEQ, OP_BNE: begin
                    bundle.is_branch = 1'b1;
                    bundle.is_bne    = (opcode == OP_BNE);
                    bundle.uses_rs   = 1'b1;
                    bundle.uses_rt   = 1'b1;
                end
                OP_RTYPE: begin
                    bundle.reg_write = 1'b1;
                    bundle.alu_op    = ALU_FUNCT;
                    bundle.dst_sel   = DST_RD;
                    bundle.uses_rs   = 1'b1;
                    bundle.uses_rt   = 1'b1;
                end
                OP_J: begin
                    bundle.is_jump = 1'b1;
                end
                OP_JAL: begin
                    bundle.is_jump   = 1'b1;
                    bundle.reg_write = 1'b1;
                    bundle.link      = 1'b1;
                    bundle.dst_sel   = DST_LINK;
                end
                OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI: begin
                    bundle.reg_write   = 1'b1;
                    bundle.alu_src_b   = 1'b1;
                    bundle.imm_command = 1'b1;
                    bundle.alu_op      = ALU_FUNCT;
                    bundle.dst_sel     = DST_RT;
                    bundle.uses_rs     = 1'b1;
                end
                // LUI reads no register: only the immediate feeds the ALU.
                OP_LUI: begin
                    bundle.reg_write   = 1'b1;
                    bundle.alu_src_b   = 1'b1;
                    bundle.imm_command = 1'b1;
                    bundle.alu_op      = ALU_LUI;
                    bundle.dst_sel     = DST_RT;
                end
                default: begin
                    bundle = bubble_bundle();
                end
            endcase
        end
    end

endmodule

// File: rtl/ctrl_pipe.sv
// ID/EX/MEM/WB control pipeline with branch resolution, hazard stalls and forwarding.
// Define CTRL_PIPE_FWD_EN to enable EX operand forwarding; otherwise RAW hazards stall.
module ctrl_pipe
    import mips_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int LINK_REG   = 31
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [5:0]            id_opcode,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  branch_eq,
    output logic [1:0]            if_pc_source,
    output logic                  if_stall,
    output logic                  id_flush,
    output logic                  ex_alu_src_b,
    output logic                  ex_imm_command,
    output logic [1:0]            ex_alu_op,
    output logic [1:0]            ex_fwd_a,
    output logic [1:0]            ex_fwd_b,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic                  wb_mem_to_reg,
    output logic                  wb_reg_write,
    output logic                  wb_link,
    output logic [REG_ADDR_W-1:0] wb_dst_reg
);

    function automatic logic hit(input logic [REG_ADDR_W-1:0] dst,
                                 input logic [REG_ADDR_W-1:0] src);
        return (dst != '0) && (dst == src);
    endfunction

    ctrl_bundle_t          dec;
    logic [REG_ADDR_W-1:0] id_dst;
    logic [REG_ADDR_W-1:0] src_rs;
    logic [REG_ADDR_W-1:0] src_rt;
    logic                  stall;
    logic                  taken;
    pc_src_e               pc_src;

    logic                  reg_write_p0, mem_to_reg_p0, mem_read_p0, mem_write_p0;
    logic                  alu_src_b_p0, imm_command_p0, link_p0;
    alu_op_e               alu_op_p0;
    logic [REG_ADDR_W-1:0] dst_p0;

    logic                  reg_write_p1, mem_to_reg_p1, mem_read_p1, mem_write_p1, link_p1;
    logic [REG_ADDR_W-1:0] dst_p1;

    logic                  reg_write_p2, mem_to_reg_p2, link_p2;
    logic [REG_ADDR_W-1:0] dst_p2;

    ctrl_decode u_decode (
        .valid  (id_valid),
        .opcode (id_opcode),
        .bundle (dec)
    );

    // ID: unused source fields are zeroed so they can never match a writer.
    assign src_rs = dec.uses_rs ? id_rs : '0;
    assign src_rt = dec.uses_rt ? id_rt : '0;

    always_comb begin
        id_dst = '0;
        case (dec.dst_sel)
            DST_RT:   id_dst = id_rt;
            DST_RD:   id_dst = id_rd;
            DST_LINK: id_dst = REG_ADDR_W'(LINK_REG);
            default:  id_dst = '0;
        endcase
    end

`ifdef CTRL_PIPE_FWD_EN
    logic load_use;
    logic branch_hazard;

    assign load_use = mem_read_p0 && (hit(dst_p0, src_rs) || hit(dst_p0, src_rt));
    // Branches compare in ID, so they must wait for any EX result and for a load in MEM.
    assign branch_hazard = dec.is_branch &&
        ((reg_write_p0 && (hit(dst_p0, src_rs) || hit(dst_p0, src_rt))) ||
         (mem_read_p1  && (hit(dst_p1, src_rs) || hit(dst_p1, src_rt))));
    assign stall = load_use || branch_hazard;
`else
    assign stall = (reg_write_p0 && (hit(dst_p0, src_rs) || hit(dst_p0, src_rt))) ||
                   (reg_write_p1 && (hit(dst_p1, src_rs) || hit(dst_p1, src_rt)));
`endif

    assign taken = dec.is_branch && (dec.is_bne ? !branch_eq : branch_eq);

    always_comb begin
        pc_src = PC_PLUS4;
        if (!stall) begin
            if (taken)            pc_src = PC_BRANCH;
            else if (dec.is_jump) pc_src = PC_JUMP;
        end
    end

    assign if_pc_source = pc_src;
    assign if_stall     = stall;
    assign id_flush     = !stall && (taken || dec.is_jump);

    // ID -> EX: a stall turns the ID/EX load into a bubble.
    always_ff @(posedge clk) begin
        if (rst || stall) begin
            reg_write_p0   <= 1'b0;
            mem_to_reg_p0  <= 1'b0;
            mem_read_p0    <= 1'b0;
            mem_write_p0   <= 1'b0;
            alu_src_b_p0   <= 1'b0;
            imm_command_p0 <= 1'b0;
            alu_op_p0      <= ALU_ADD;
            link_p0        <= 1'b0;
            dst_p0         <= '0;
        end else begin
            reg_write_p0   <= dec.reg_write;
            mem_to_reg_p0  <= dec.mem_to_reg;
            mem_read_p0    <= dec.mem_read;
            mem_write_p0   <= dec.mem_write;
            alu_src_b_p0   <= dec.alu_src_b;
            imm_command_p0 <= dec.imm_command;
            alu_op_p0      <= dec.alu_op;
            link_p0        <= dec.link;
            dst_p0         <= id_dst;
        end
    end

    // EX -> MEM -> WB: these stages keep advancing through stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            reg_write_p1  <= 1'b0;
            mem_to_reg_p1 <= 1'b0;
            mem_read_p1   <= 1'b0;
            mem_write_p1  <= 1'b0;
            link_p1       <= 1'b0;
            dst_p1        <= '0;
            reg_write_p2  <= 1'b0;
            mem_to_reg_p2 <= 1'b0;
            link_p2       <= 1'b0;
            dst_p2        <= '0;
        end else begin
            reg_write_p1  <= reg_write_p0;
            mem_to_reg_p1 <= mem_to_reg_p0;
            mem_read_p1   <= mem_read_p0;
            mem_write_p1  <= mem_write_p0;
            link_p1       <= link_p0;
            dst_p1        <= dst_p0;
            reg_write_p2  <= reg_write_p1;
            mem_to_reg_p2 <= mem_to_reg_p1;
            link_p2       <= link_p1;
            dst_p2        <= dst_p1;
        end
    end

`ifdef CTRL_PIPE_FWD_EN
    logic [REG_ADDR_W-1:0] rs_p0;
    logic [REG_ADDR_W-1:0] rt_p0;
    fwd_e                  fwd_a;
    fwd_e                  fwd_b;

    always_ff @(posedge clk) begin
        if (rst || stall) begin
            rs_p0 <= '0;
            rt_p0 <= '0;
        end else begin
            rs_p0 <= src_rs;
            rt_p0 <= src_rt;
        end
    end

    // The youngest writer (EX/MEM) wins over MEM/WB.
    always_comb begin
        fwd_a = FWD_REG;
        fwd_b = FWD_REG;
        if (reg_write_p1 && hit(dst_p1, rs_p0))      fwd_a = FWD_EXMEM;
        else if (reg_write_p2 && hit(dst_p2, rs_p0)) fwd_a = FWD_MEMWB;
        if (reg_write_p1 && hit(dst_p1, rt_p0))      fwd_b = FWD_EXMEM;
        else if (reg_write_p2 && hit(dst_p2, rt_p0)) fwd_b = FWD_MEMWB;
    end

    assign ex_fwd_a = fwd_a;
    assign ex_fwd_b = fwd_b;
`else
    assign ex_fwd_a = FWD_REG;
    assign ex_fwd_b = FWD_REG;
`endif

    assign ex_alu_src_b   = alu_src_b_p0;
    assign ex_imm_command = imm_command_p0;
    assign ex_alu_op      = alu_op_p0;
    assign mem_read       = mem_read_p1;
    assign mem_write      = mem_write_p1;
    assign wb_mem_to_reg  = mem_to_reg_p2;
    assign wb_reg_write   = reg_write_p2;
    assign wb_link        = link_p2;
    assign wb_dst_reg     = dst_p2;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Randomized self-checking bench for ctrl_pipe against an instruction-level reference model.
// Builds with or without CTRL_PIPE_FWD_EN; expectations follow the same macro.
module tb_ctrl_pipe;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid;
    logic [5:0] id_opcode;
    logic [4:0] id_rs, id_rt, id_rd;
    logic       branch_eq;
    logic [1:0] if_pc_source;
    logic       if_stall, id_flush;
    logic       ex_alu_src_b, ex_imm_command;
    logic [1:0] ex_alu_op, ex_fwd_a, ex_fwd_b;
    logic       mem_read, mem_write;
    logic       wb_mem_to_reg, wb_reg_write, wb_link;
    logic [4:0] wb_dst_reg;

    always #5 clk = ~clk;

    ctrl_pipe #(.REG_ADDR_W(5), .LINK_REG(31)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .branch_eq(branch_eq),
        .if_pc_source(if_pc_source), .if_stall(if_stall), .id_flush(id_flush),
        .ex_alu_src_b(ex_alu_src_b), .ex_imm_command(ex_imm_command), .ex_alu_op(ex_alu_op),
        .ex_fwd_a(ex_fwd_a), .ex_fwd_b(ex_fwd_b), .mem_read(mem_read), .mem_write(mem_write),
        .wb_mem_to_reg(wb_mem_to_reg), .wb_reg_write(wb_reg_write), .wb_link(wb_link),
        .wb_dst_reg(wb_dst_reg)
    );

    typedef struct {
        bit       known;
        bit [5:0] op;
        bit [4:0] rs, rt, rd;
    } instr_t;

    typedef struct {
        bit       writes, load, store, branch, bne, jump, link, src_b, imm, rs_used, rt_used;
        bit [1:0] alu_op;
        bit [4:0] dst;
    } props_t;

    int     n_checks = 0;
    int     n_fail   = 0;
    instr_t cur, ex_i, mem_i, wb_i;
    bit     m_stall;
    bit [5:0] op_tbl [15] = '{6'h23, 6'h2b, 6'h04, 6'h05, 6'h00, 6'h02, 6'h03, 6'h08,
                              6'h0c, 6'h0d, 6'h0e, 6'h0a, 6'h0f, 6'h3f, 6'h10};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic props_t props(instr_t i);
        props_t p = '{default: 0};
        if (!i.known) return p;
        case (i.op)
            6'h23: begin p.writes = 1; p.load = 1; p.src_b = 1; p.rs_used = 1; p.dst = i.rt; end
            6'h2b: begin p.store = 1; p.src_b = 1; p.rs_used = 1; p.rt_used = 1; end
            6'h04: begin p.branch = 1; p.rs_used = 1; p.rt_used = 1; end
            6'h05: begin p.branch = 1; p.bne = 1; p.rs_used = 1; p.rt_used = 1; end
            6'h00: begin p.writes = 1; p.alu_op = 2; p.rs_used = 1; p.rt_used = 1; p.dst = i.rd; end
            6'h02: begin p.jump = 1; end
            6'h03: begin p.jump = 1; p.writes = 1; p.link = 1; p.dst = 5'd31; end
            6'h08, 6'h0c, 6'h0d, 6'h0e, 6'h0a: begin
                p.writes = 1; p.src_b = 1; p.imm = 1; p.alu_op = 2; p.rs_used = 1; p.dst = i.rt;
            end
            6'h0f: begin p.writes = 1; p.src_b = 1; p.imm = 1; p.alu_op = 3; p.dst = i.rt; end
            default: p = '{default: 0};
        endcase
        return p;
    endfunction

    // True when writer w produces a nonzero register that reader r actually reads.
    function automatic bit dep(props_t w, props_t r, instr_t ri);
        return w.writes && (w.dst != 0) &&
               ((r.rs_used && ri.rs == w.dst) || (r.rt_used && ri.rt == w.dst));
    endfunction

    function automatic int fwd_for(bit used, bit [4:0] src, props_t m, props_t w);
`ifdef CTRL_PIPE_FWD_EN
        if (!used || src == 0) return 0;
        if (m.writes && m.dst == src) return 2;
        if (w.writes && w.dst == src) return 1;
        return 0;
`else
        return 0;
`endif
    endfunction

    task automatic compare(input bit beq);
        props_t id = props(cur);
        props_t e  = props(ex_i);
        props_t m  = props(mem_i);
        props_t w  = props(wb_i);
        bit     taken;
        int     pc;
`ifdef CTRL_PIPE_FWD_EN
        m_stall = (e.load && dep(e, id, cur)) ||
                  (id.branch && (dep(e, id, cur) || (m.load && dep(m, id, cur))));
`else
        m_stall = dep(e, id, cur) || dep(m, id, cur);
`endif
        taken = id.branch && (id.bne ? !beq : beq);
        pc    = m_stall ? 0 : (taken ? 1 : (id.jump ? 2 : 0));
        check_eq("if_stall",       32'(if_stall),       32'(m_stall));
        check_eq("if_pc_source",   32'(if_pc_source),   pc);
        check_eq("id_flush",       32'(id_flush),       32'(!m_stall && (taken || id.jump)));
        check_eq("ex_alu_src_b",   32'(ex_alu_src_b),   32'(e.src_b));
        check_eq("ex_imm_command", 32'(ex_imm_command), 32'(e.imm));
        check_eq("ex_alu_op",      32'(ex_alu_op),      32'(e.alu_op));
        check_eq("ex_fwd_a",       32'(ex_fwd_a),       fwd_for(e.rs_used, ex_i.rs, m, w));
        check_eq("ex_fwd_b",       32'(ex_fwd_b),       fwd_for(e.rt_used, ex_i.rt, m, w));
        check_eq("mem_read",       32'(mem_read),       32'(m.load));
        check_eq("mem_write",      32'(mem_write),      32'(m.store));
        check_eq("wb_mem_to_reg",  32'(wb_mem_to_reg),  32'(w.load));
        check_eq("wb_reg_write",   32'(wb_reg_write),   32'(w.writes));
        check_eq("wb_link",        32'(wb_link),        32'(w.link));
        check_eq("wb_dst_reg",     32'(wb_dst_reg),     32'(w.dst));
    endtask

    task automatic advance(input bit r);
        instr_t bub = '{default: 0};
        if (r) begin
            ex_i = bub; mem_i = bub; wb_i = bub;
        end else begin
            wb_i  = mem_i;
            mem_i = ex_i;
            ex_i  = m_stall ? bub : cur;
        end
    endtask

    // One cycle: drive on the falling edge, check, then advance the model across the rising edge.
    task automatic step(input bit r, input bit v, input bit [5:0] op,
                        input bit [4:0] rs, input bit [4:0] rt, input bit [4:0] rd, input bit beq);
        @(negedge clk);
        rst = r; id_valid = v; id_opcode = op; id_rs = rs; id_rt = rt; id_rd = rd; branch_eq = beq;
        cur = '{known: v, op: op, rs: rs, rt: rt, rd: rd};
        #1;
        compare(beq);
        advance(r);
    endtask

    task automatic nops(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 6'h00, 0, 0, 0, 0);
    endtask

    // Re-presents an instruction while the DUT stalls; returns the stall count.
    task automatic hold(input bit [5:0] op, input bit [4:0] rs, input bit [4:0] rt,
                        input bit [4:0] rd, input bit beq, output int n);
        n = 0;
        step(0, 1, op, rs, rt, rd, beq);
        while (if_stall && n < 5) begin
            n++;
            step(0, 1, op, rs, rt, rd, beq);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int exp_ld, exp_raw, exp_br, exp_fa_ld, exp_fa_raw;
        bit [5:0] op;
        bit [4:0] rs, rt, rd;
        bit v;
        bit beq;
`ifdef CTRL_PIPE_FWD_EN
        exp_ld = 1; exp_raw = 0; exp_br = 1; exp_fa_ld = 1; exp_fa_raw = 2;
`else
        exp_ld = 2; exp_raw = 2; exp_br = 2; exp_fa_ld = 0; exp_fa_raw = 0;
`endif
        rst = 1; id_valid = 0; id_opcode = 0; id_rs = 0; id_rt = 0; id_rd = 0; branch_eq = 0;
        cur = '{default: 0}; ex_i = cur; mem_i = cur; wb_i = cur; m_stall = 0;

        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        check_eq("rst_wb_reg_write", 32'(wb_reg_write), 0);
        check_eq("rst_wb_dst_reg",   32'(wb_dst_reg),   0);
        check_eq("rst_ex_fwd_a",     32'(ex_fwd_a),     0);

        // Load-use: LW $2 then ADD $3,$2,$4.
        step(0, 1, 6'h23, 1, 2, 0, 0);
        hold(6'h00, 2, 4, 3, 0, n);
        check_eq("ld_use_stalls", n, exp_ld);
        check_eq("ld_use_bubble_op", 32'(ex_alu_op), 0);
        check_eq("ld_use_bubble_srcb", 32'(ex_alu_src_b), 0);
        nops(1);
        check_eq("ld_use_fwd_a", 32'(ex_fwd_a), exp_fa_ld);

        // Back-to-back ALU dependency.
        nops(3);
        step(0, 1, 6'h00, 1, 1, 5, 0);
        hold(6'h00, 5, 6, 7, 0, n);
        check_eq("raw_stalls", n, exp_raw);
        nops(1);
        check_eq("raw_fwd_a", 32'(ex_fwd_a), exp_fa_raw);

        // Branch depending on an ALU result still in EX.
        nops(3);
        step(0, 1, 6'h00, 1, 1, 5, 0);
        hold(6'h04, 5, 5, 0, 1, n);
        check_eq("br_haz_stalls", n, exp_br);
        check_eq("br_haz_pc", 32'(if_pc_source), 1);

        // BNE taken / not taken.
        nops(3);
        step(0, 1, 6'h05, 1, 2, 0, 0);
        check_eq("bne_taken_pc", 32'(if_pc_source), 1);
        check_eq("bne_taken_flush", 32'(id_flush), 1);
        step(0, 1, 6'h05, 1, 2, 0, 1);
        check_eq("bne_nt_pc", 32'(if_pc_source), 0);
        check_eq("bne_nt_flush", 32'(id_flush), 0);

        // JAL and its link writeback three cycles later.
        nops(3);
        step(0, 1, 6'h03, 7, 9, 3, 0);
        check_eq("jal_pc", 32'(if_pc_source), 2);
        check_eq("jal_flush", 32'(id_flush), 1);
        nops(3);
        check_eq("jal_wb_reg_write", 32'(wb_reg_write), 1);
        check_eq("jal_wb_link", 32'(wb_link), 1);
        check_eq("jal_wb_dst", 32'(wb_dst_reg), 31);

        // Writes to $0 never create hazards; unknown opcode is a bubble.
        nops(3);
        step(0, 1, 6'h08, 1, 0, 0, 0);
        step(0, 1, 6'h00, 0, 0, 3, 0);
        check_eq("zero_no_stall", 32'(if_stall), 0);
        nops(1);
        check_eq("zero_fwd_a", 32'(ex_fwd_a), 0);
        check_eq("zero_fwd_b", 32'(ex_fwd_b), 0);
        step(0, 1, 6'h3f, 3, 4, 5, 1);
        check_eq("unk_pc", 32'(if_pc_source), 0);
        step(0, 0, 0, 0, 0, 0, 0);
        check_eq("unk_ex_srcb", 32'(ex_alu_src_b), 0);
        check_eq("unk_ex_imm", 32'(ex_imm_command), 0);

        // Reset in the middle of a load-use stall.
        nops(3);
        step(0, 1, 6'h23, 1, 2, 0, 0);
        step(0, 1, 6'h00, 2, 4, 3, 0);
        check_eq("rst_stall_pre", 32'(if_stall), 1);
        step(1, 1, 6'h00, 2, 4, 3, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        check_eq("rst_stall_if_stall", 32'(if_stall), 0);
        check_eq("rst_stall_mem_read", 32'(mem_read), 0);
        check_eq("rst_stall_ex_op", 32'(ex_alu_op), 0);
        check_eq("rst_stall_wb_write", 32'(wb_reg_write), 0);

        // Random instruction stream; a stalled instruction is re-presented unchanged.
        op = 0; rs = 0; rt = 0; rd = 0; v = 0; beq = 0;
        for (int c = 0; c < 600; c++) begin
            if (!m_stall) begin
                v  = ($urandom_range(0, 9) != 0);
                op = op_tbl[$urandom_range(0, 14)];
                rs = 5'($urandom_range(0, 7));
                rt = 5'($urandom_range(0, 7));
                rd = ($urandom_range(0, 15) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
                if ($urandom_range(0, 15) == 0) rs = 5'd31;
            end
            beq = 1'($urandom_range(0, 1));
            step(($urandom_range(0, 79) == 0), v, op, rs, rt, rd, beq);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
